seven_seg_scanner: RTL and testbench

Time-multiplexed seven-segment display driver for the stopwatch. It consumes packed BCD digits from the digit counter chain and drives the board's common-anode display: one digit is lit at a time, at a programmable refresh rate. It sits between the counter datapath and the FPGA display pins. Digits are captured once per scan frame, so a display frame never shows a mix of old and new counter values.

---
 rtl/seven_seg_scanner_if.sv | 24 ++
 rtl/seven_seg_scanner.sv | 105 ++++++++++
 tb/tb_seven_seg_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for the seven-segment scanner: digit/dp requests in,
// active-low anode/segment drive and the frame snapshot pulse out.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    blank_lead;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output enable, blank_lead, digits_in, dp_in,
    input  anode, seg, dp, frame_done
  );

  modport slave (
    input  enable, blank_lead, digits_in, dp_in,
    output anode, seg, dp, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver. Digits are snapshotted
// once per scan frame so a frame never mixes old and new counter values.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic                 clk,
  input logic                 rst,
  seven_seg_scanner_if.slave  bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]                r_presc;
  logic [IW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0][3:0]   r_snap;
  logic [NUM_DIGITS-1:0]        r_snapDp;
  logic                         r_primed;
  logic                         r_loaded;
  logic [NUM_DIGITS-1:0]        r_anode;
  logic [6:0]                   r_seg;
  logic                         r_dp;
  logic                         r_frameDone;

  logic                         w_tick;
  logic                         w_lastIdx;
  logic                         w_load;
  logic [3:0]                   w_digit;
  logic [6:0]                   w_segDec;
  logic                         w_upperZero;
  logic                         w_blank;
  logic [NUM_DIGITS-1:0]        w_sel;

  assign w_tick    = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_lastIdx = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_load    = !r_primed || (w_tick && w_lastIdx);
  assign w_digit   = r_snap[r_idx];
  assign w_sel     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  // Segment decode ({g,f,e,d,c,b,a}, active low) and leading-zero detection
  // over the current digit and everything more significant than it.
  always_comb begin
    w_segDec    = 7'b0111111;
    w_upperZero = 1'b1;
    case (w_digit)
      4'd0: w_segDec = 7'b1000000;
      4'd1: w_segDec = 7'b1111001;
      4'd2: w_segDec = 7'b0100100;
      4'd3: w_segDec = 7'b0110000;
      4'd4: w_segDec = 7'b0011001;
      4'd5: w_segDec = 7'b0010010;
      4'd6: w_segDec = 7'b0000010;
      4'd7: w_segDec = 7'b1111000;
      4'd8: w_segDec = 7'b0000000;
      4'd9: w_segDec = 7'b0010000;
      default: w_segDec = 7'b0111111;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(r_idx) && r_snap[i] != 4'd0) begin
        w_upperZero = 1'b0;
      end
    end
    w_blank = bus.blank_lead && w_upperZero && (r_idx != '0);
  end

  // The prescaler holds during the priming cycle so digit 0's window starts
  // together with the first registered display of the fresh snapshot; the
  // frame_done flag is delayed a stage to line up with that display too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_snap      <= '0;
      r_snapDp    <= '0;
      r_primed    <= 1'b0;
      r_loaded    <= 1'b0;
      r_anode     <= '1;
      r_seg       <= '1;
      r_dp        <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      if (r_primed) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_idx <= w_lastIdx ? '0 : r_idx + 1'b1;
        end
      end
      if (w_load) begin
        r_snap   <= bus.digits_in;
        r_snapDp <= bus.dp_in;
      end
      r_loaded    <= w_load;
      r_frameDone <= r_loaded;
      r_anode     <= (bus.enable && r_primed) ? ~w_sel : '1;
      r_seg       <= (w_blank || !r_primed) ? 7'b1111111 : w_segDec;
      r_dp        <= (w_blank || !r_primed) ? 1'b1 : ~r_snapDp[r_idx];
    end
  end

  assign bus.anode      = r_anode;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frameDone;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4;
// cycle 0 is the first edge with rst low, checks sample 1ns after each edge.
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [3:0] anodeTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic startRun(input logic [15:0] d, input logic [3:0] dpv, input logic bl);
    rst            = 1'b1;
    bus.digits_in  = d;
    bus.dp_in      = dpv;
    bus.blank_lead = bl;
    bus.enable     = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.digits_in = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checks += 4;
      if (bus.anode !== 4'b1111) begin errors++; $display("[TB] FAIL reset_anode got=%b exp=1111", bus.anode); end
      if (bus.seg !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_seg got=%b exp=1111111", bus.seg); end
      if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp got=%b exp=1", bus.dp); end
      if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fd got=%b exp=0", bus.frame_done); end
    end
  endtask

  task automatic test_basic_scan();
    logic [6:0] segTab [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    int k;
    logic expFd;
    startRun(16'h1234, 4'b0000, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      applyStimulus();
      k     = ((cyc - 1) / RD) % ND;
      expFd = ((cyc - 1) % (ND * RD)) == 0;
      checks += 4;
      if (bus.anode !== anodeTab[k]) begin errors++; $display("[TB] FAIL scan_anode cyc=%0d got=%b exp=%b", cyc, bus.anode, anodeTab[k]); end
      if (bus.seg !== segTab[k]) begin errors++; $display("[TB] FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, segTab[k]); end
      if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL scan_dp cyc=%0d got=%b exp=1", cyc, bus.dp); end
      if (bus.frame_done !== expFd) begin errors++; $display("[TB] FAIL scan_fd cyc=%0d got=%b exp=%b", cyc, bus.frame_done, expFd); end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] segOn  [4] = '{7'b0010010, 7'b0011001, 7'b1111111, 7'b1111111};
    logic [6:0] segOff [4] = '{7'b0010010, 7'b0011001, 7'b1000000, 7'b1000000};
    logic [6:0] expSeg;
    int k;
    startRun(16'h0045, 4'b0000, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      applyStimulus();
      k      = ((cyc - 1) / RD) % ND;
      expSeg = (cyc <= 16) ? segOn[k] : segOff[k];
      checks += 3;
      if (bus.anode !== anodeTab[k]) begin errors++; $display("[TB] FAIL blank_anode cyc=%0d got=%b exp=%b", cyc, bus.anode, anodeTab[k]); end
      if (bus.seg !== expSeg) begin errors++; $display("[TB] FAIL blank_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, expSeg); end
      if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL blank_dp cyc=%0d got=%b exp=1", cyc, bus.dp); end
      if (cyc == 16) bus.blank_lead = 1'b0;
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] segOld [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    logic [6:0] segNew [4] = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    logic [6:0] expSeg;
    logic expFd;
    int k;
    startRun(16'h1234, 4'b0000, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      applyStimulus();
      k      = ((cyc - 1) / RD) % ND;
      expSeg = (cyc <= 16) ? segOld[k] : segNew[k];
      expFd  = (cyc == 1) || (cyc == 17);
      checks += 3;
      if (bus.anode !== anodeTab[k]) begin errors++; $display("[TB] FAIL snap_anode cyc=%0d got=%b exp=%b", cyc, bus.anode, anodeTab[k]); end
      if (bus.seg !== expSeg) begin errors++; $display("[TB] FAIL snap_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, expSeg); end
      if (bus.frame_done !== expFd) begin errors++; $display("[TB] FAIL snap_fd cyc=%0d got=%b exp=%b", cyc, bus.frame_done, expFd); end
      if (cyc == 6) bus.digits_in = 16'h5678;
    end
  endtask

  task automatic test_error_dp_enable();
    logic [6:0] segTab [4] = '{7'b0111111, 7'b0110000, 7'b0100100, 7'b1111001};
    logic expDp;
    logic [3:0] expAn;
    int k;
    startRun(16'h123A, 4'b0001, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      applyStimulus();
      k     = ((cyc - 1) / RD) % ND;
      expDp = (k == 0) ? 1'b0 : 1'b1;
      expAn = (cyc == 10) ? 4'b1111 : anodeTab[k];
      checks += 3;
      if (bus.anode !== expAn) begin errors++; $display("[TB] FAIL en_anode cyc=%0d got=%b exp=%b", cyc, bus.anode, expAn); end
      if (bus.seg !== segTab[k]) begin errors++; $display("[TB] FAIL err_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, segTab[k]); end
      if (bus.dp !== expDp) begin errors++; $display("[TB] FAIL dp_out cyc=%0d got=%b exp=%b", cyc, bus.dp, expDp); end
      bus.enable = (cyc == 9) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_midframe_reset();
    startRun(16'h1234, 4'b0000, 1'b0);
    for (int c = 1; c <= 9; c++) applyStimulus();
    checks++;
    if (bus.anode !== 4'b1011) begin errors++; $display("[TB] FAIL mid_pre_anode got=%b exp=1011", bus.anode); end
    rst = 1'b1;
    applyStimulus();
    checks += 4;
    if (bus.anode !== 4'b1111) begin errors++; $display("[TB] FAIL mid_anode got=%b exp=1111", bus.anode); end
    if (bus.seg !== 7'b1111111) begin errors++; $display("[TB] FAIL mid_seg got=%b exp=1111111", bus.seg); end
    if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL mid_dp got=%b exp=1", bus.dp); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_fd got=%b exp=0", bus.frame_done); end
    rst = 1'b0;
    applyStimulus();
    cyc = 0;
    applyStimulus();
    checks += 3;
    if (bus.frame_done !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_fd got=%b exp=1", bus.frame_done); end
    if (bus.anode !== 4'b1110) begin errors++; $display("[TB] FAIL mid_restart_anode got=%b exp=1110", bus.anode); end
    if (bus.seg !== 7'b0011001) begin errors++; $display("[TB] FAIL mid_restart_seg got=%b exp=0011001", bus.seg); end
    applyStimulus();
    checks++;
    if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_fd_once got=%b exp=0", bus.frame_done); end
    for (int c = 3; c <= 5; c++) applyStimulus();
    checks++;
    if (bus.anode !== 4'b1101) begin errors++; $display("[TB] FAIL mid_digit1_anode got=%b exp=1101", bus.anode); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.enable     = 1'b1;
    bus.blank_lead = 1'b0;
    bus.digits_in  = 16'h9999;
    bus.dp_in      = 4'b0000;
    test_reset();
    test_basic_scan();
    test_blanking();
    test_snapshot();
    test_error_dp_enable();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
